// File: rtl/ddr_app_arbiter.sv
`timescale 1ns/1ps
// ddr_app_arbiter: shares one MIG 7-series app_* interface between two requesters (single-beat ops).
// Optional macro DDR_ARB_FIXED_PRIORITY_EN: port 0 always wins contention instead of round-robin.
module ddr_app_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 28,
    parameter int unsigned APP_DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH     = 16,
    parameter int unsigned RD_FIFO_DEPTH  = 16
) (
    input  logic                      ui_clk,
    input  logic                      ui_clk_sync_rst,
    input  logic                      init_calib_complete,

    input  logic                      p0_req_valid,
    output logic                      p0_req_ready,
    input  logic                      p0_req_write,
    input  logic [ADDR_WIDTH-1:0]     p0_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p0_req_wdata,
    input  logic [MASK_WIDTH-1:0]     p0_req_wmask,
    output logic                      p0_rsp_valid,
    output logic [APP_DATA_WIDTH-1:0] p0_rsp_data,

    input  logic                      p1_req_valid,
    output logic                      p1_req_ready,
    input  logic                      p1_req_write,
    input  logic [ADDR_WIDTH-1:0]     p1_req_addr,
    input  logic [APP_DATA_WIDTH-1:0] p1_req_wdata,
    input  logic [MASK_WIDTH-1:0]     p1_req_wmask,
    output logic                      p1_rsp_valid,
    output logic [APP_DATA_WIDTH-1:0] p1_rsp_data,

    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic [2:0]                app_cmd,
    output logic                      app_en,
    input  logic                      app_rdy,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic [MASK_WIDTH-1:0]     app_wdf_mask,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    input  logic                      app_wdf_rdy,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    input  logic                      app_rd_data_valid,
    input  logic                      app_rd_data_end,
    output logic                      err_unexpected_rd
);

    localparam int unsigned PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_cmd_done;
    logic                      r_wdf_done;
    logic                      w_cmd_done_nxt;
    logic                      w_wdf_done_nxt;

    logic                      r_write;
    logic                      r_port;
    logic [2:0]                r_cmd;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [APP_DATA_WIDTH-1:0] r_wdata;
    logic [MASK_WIDTH-1:0]     r_wmask;

    logic                      r_tag_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    logic                      r_p0_rsp_valid;
    logic                      r_p1_rsp_valid;
    logic [APP_DATA_WIDTH-1:0] r_p0_rsp_data;
    logic [APP_DATA_WIDTH-1:0] r_p1_rsp_data;
    logic                      r_err;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_elig0;
    logic                      w_elig1;
    logic                      w_grant_any;
    logic                      w_grant_port;
    logic                      w_sel_write;
    logic [ADDR_WIDTH-1:0]     w_sel_addr;
    logic [APP_DATA_WIDTH-1:0] w_sel_wdata;
    logic [MASK_WIDTH-1:0]     w_sel_wmask;
    logic                      w_cmd_fire;
    logic                      w_wdf_fire;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_head_tag;
    logic                      w_unused;

    assign w_unused     = app_rd_data_end;

    assign w_fifo_full  = (r_count == CNT_W'(RD_FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);

    // Writes never touch the tag FIFO, so only reads are throttled by its occupancy.
    assign w_elig0 = p0_req_valid && (p0_req_write || !w_fifo_full);
    assign w_elig1 = p1_req_valid && (p1_req_write || !w_fifo_full);

    assign w_grant_any = (r_state == S_IDLE) && init_calib_complete && !ui_clk_sync_rst
                         && (w_elig0 || w_elig1);

`ifdef DDR_ARB_FIXED_PRIORITY_EN
    assign w_grant_port = !w_elig0;
`else
    logic r_last_grant;

    always_comb begin
        if (w_elig0 && w_elig1) begin
            w_grant_port = !r_last_grant;
        end else begin
            w_grant_port = !w_elig0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_port;
        end
    end
`endif

    assign p0_req_ready = w_grant_any && !w_grant_port;
    assign p1_req_ready = w_grant_any &&  w_grant_port;

    assign w_sel_write = w_grant_port ? p1_req_write : p0_req_write;
    assign w_sel_addr  = w_grant_port ? p1_req_addr  : p0_req_addr;
    assign w_sel_wdata = w_grant_port ? p1_req_wdata : p0_req_wdata;
    assign w_sel_wmask = w_grant_port ? p1_req_wmask : p0_req_wmask;

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_write <= 1'b0;
            r_port  <= 1'b0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_grant_any) begin
            r_write <= w_sel_write;
            r_port  <= w_grant_port;
            r_cmd   <= w_sel_write ? 3'b000 : 3'b001;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wmask <= w_sel_wmask;
        end
    end

    assign w_cmd_fire = app_en && app_rdy;
    assign w_wdf_fire = app_wdf_wren && app_wdf_rdy;

    always_comb begin
        w_state_nxt    = r_state;
        w_cmd_done_nxt = r_cmd_done;
        w_wdf_done_nxt = r_wdf_done;
        app_en         = 1'b0;
        app_wdf_wren   = 1'b0;
        app_wdf_end    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_state_nxt    = S_ISSUE;
                    w_cmd_done_nxt = 1'b0;
                    w_wdf_done_nxt = 1'b0;
                end
            end
            S_ISSUE: begin
                app_en         = !r_cmd_done;
                app_wdf_wren   = r_write && !r_wdf_done;
                app_wdf_end    = r_write && !r_wdf_done;
                // Command and data channels close independently; leave once both are closed.
                w_cmd_done_nxt = r_cmd_done || (app_en && app_rdy);
                w_wdf_done_nxt = r_wdf_done || (app_wdf_wren && app_wdf_rdy);
                if (w_cmd_done_nxt && (w_wdf_done_nxt || !r_write)) begin
                    w_state_nxt    = S_IDLE;
                    w_cmd_done_nxt = 1'b0;
                    w_wdf_done_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_state    <= S_IDLE;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_done <= w_cmd_done_nxt;
            r_wdf_done <= w_wdf_done_nxt;
        end
    end

    assign app_addr     = r_addr;
    assign app_cmd      = r_cmd;
    assign app_wdf_data = r_wdata;
    assign app_wdf_mask = r_wmask;

    assign w_push     = w_cmd_fire && !r_write;
    assign w_pop      = app_rd_data_valid && !w_fifo_empty;
    assign w_head_tag = r_tag_mem[r_rd_ptr];

    always_ff @(posedge ui_clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_port;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RD_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_p0_rsp_valid <= 1'b0;
            r_p1_rsp_valid <= 1'b0;
            r_p0_rsp_data  <= '0;
            r_p1_rsp_data  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_p0_rsp_valid <= w_pop && !w_head_tag;
            r_p1_rsp_valid <= w_pop &&  w_head_tag;
            if (w_pop && !w_head_tag) begin
                r_p0_rsp_data <= app_rd_data;
            end
            if (w_pop && w_head_tag) begin
                r_p1_rsp_data <= app_rd_data;
            end
            if (app_rd_data_valid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign p0_rsp_valid      = r_p0_rsp_valid;
    assign p1_rsp_valid      = r_p1_rsp_valid;
    assign p0_rsp_data       = r_p0_rsp_data;
    assign p1_rsp_data       = r_p1_rsp_data;
    assign err_unexpected_rd = r_err;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
`timescale 1ns/1ps
// Directed bench for ddr_app_arbiter: arbitration vector table plus hand-written handshake,
// read-return, FIFO-full, error and reset sequences. Built with RD_FIFO_DEPTH=4.
module tb_ddr_app_arbiter;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = 16;

    logic          ui_clk = 1'b0;
    logic          ui_clk_sync_rst;
    logic          init_calib_complete;
    logic          p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_data;
    logic [MW-1:0] p0_req_wmask;
    logic          p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_data;
    logic [MW-1:0] p1_req_wmask;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid, app_rd_data_end;
    logic          err_unexpected_rd;

    int total = 0;
    int bad   = 0;
    int n_cmd_hs = 0;
    int n_wdf_hs = 0;

    typedef struct {
        logic calib;
        logic v0, w0, v1, w1;
        logic g0, g1;
    } vec_t;
    vec_t vecs [7];

    always #5 ui_clk = ~ui_clk;

    ddr_app_arbiter #(
        .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .MASK_WIDTH(MW), .RD_FIFO_DEPTH(4)
    ) dut (
        .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .init_calib_complete(init_calib_complete),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_wmask(p0_req_wmask),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_wmask(p1_req_wmask),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .err_unexpected_rd(err_unexpected_rd)
    );

    always @(posedge ui_clk) begin
        if (!ui_clk_sync_rst) begin
            if (app_en && app_rdy) n_cmd_hs <= n_cmd_hs + 1;
            if (app_wdf_wren && app_wdf_rdy) n_wdf_hs <= n_wdf_hs + 1;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " app_en"}, app_en, 0);
        chk({tag, " app_cmd"}, app_cmd, 0);
        chk({tag, " app_addr"}, app_addr, 0);
        chk({tag, " wren"}, app_wdf_wren, 0);
        chk({tag, " wdf_end"}, app_wdf_end, 0);
        chk({tag, " wdf_data"}, app_wdf_data, 0);
        chk({tag, " wdf_mask"}, app_wdf_mask, 0);
        chk({tag, " ready0"}, p0_req_ready, 0);
        chk({tag, " ready1"}, p1_req_ready, 0);
        chk({tag, " rsp0_valid"}, p0_rsp_valid, 0);
        chk({tag, " rsp1_valid"}, p1_rsp_valid, 0);
        chk({tag, " err"}, err_unexpected_rd, 0);
    endtask

    task automatic issue_read(input logic port, input logic [AW-1:0] addr);
        @(negedge ui_clk);
        if (port) begin
            p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = addr;
        end else begin
            p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = addr;
        end
        #1;
        chk("rd grant ready0", p0_req_ready, !port);
        chk("rd grant ready1", p1_req_ready, port);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        #1;
        chk("rd issue app_en", app_en, 1);
        chk("rd issue app_cmd", app_cmd, 3'b001);
        chk("rd issue app_addr", app_addr, addr);
    endtask

    task automatic do_return(input logic [DW-1:0] data, input logic port);
        @(negedge ui_clk);
        app_rd_data       = data;
        app_rd_data_valid = 1'b1;
        #1;
        chk("ret early rsp0_valid", p0_rsp_valid, 0);
        chk("ret early rsp1_valid", p1_rsp_valid, 0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
        #1;
        chk("ret rsp0_valid", p0_rsp_valid, !port);
        chk("ret rsp1_valid", p1_rsp_valid, port);
        if (port) chk("ret rsp1_data", p1_rsp_data, data);
        else      chk("ret rsp0_data", p0_rsp_data, data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w1;
        logic [2:0]    exp_cmd;
        logic [AW-1:0] exp_addr;
        logic          exp_en, exp_wr;
        int            cmd0, wdf0;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // FIFO full: p0 read blocked
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // calibration low

        ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_wmask = '0;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_wmask = '0;
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;

        repeat (3) @(negedge ui_clk);
        #1;
        check_all_zero("reset");
        @(negedge ui_clk);
        ui_clk_sync_rst = 1'b0;

        // Single write from p0
        w1 = 128'h0123456789ABCDEF0123456789ABCDEF;
        @(negedge ui_clk);
        init_calib_complete = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        p0_req_valid = 1'b1; p0_req_write = 1'b1; p0_req_addr = 28'h0000010;
        p0_req_wdata = w1; p0_req_wmask = '0;
        #1;
        chk("wr ready0", p0_req_ready, 1);
        chk("wr ready1", p1_req_ready, 0);
        chk("wr grant app_en", app_en, 0);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        #1;
        chk("wr app_en", app_en, 1);
        chk("wr app_cmd", app_cmd, 3'b000);
        chk("wr wren", app_wdf_wren, 1);
        chk("wr wdf_end", app_wdf_end, 1);
        chk("wr app_addr", app_addr, 28'h0000010);
        chk("wr wdf_data", app_wdf_data, w1);
        chk("wr wdf_mask", app_wdf_mask, 0);
        chk("wr ready0 in issue", p0_req_ready, 0);
        @(negedge ui_clk);
        #1;
        chk("wr done app_en", app_en, 0);
        chk("wr done wren", app_wdf_wren, 0);

        // Staggered ready: wdf_rdy low 3 cycles, app_rdy low 5 cycles
        @(negedge ui_clk);
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        p1_req_valid = 1'b1; p1_req_write = 1'b1; p1_req_addr = 28'h0000020;
        p1_req_wdata = {4{32'hA5A50F0F}}; p1_req_wmask = 16'h00FF;
        #1;
        chk("stg ready1", p1_req_ready, 1);
        chk("stg ready0", p0_req_ready, 0);
        cmd0 = n_cmd_hs;
        wdf0 = n_wdf_hs;
        for (int c = 0; c < 7; c++) begin
            @(negedge ui_clk);
            p1_req_valid = 1'b0;
            app_wdf_rdy  = (c >= 3);
            app_rdy      = (c >= 5);
            #1;
            chk($sformatf("stg c%0d app_en", c), app_en, (c <= 5));
            chk($sformatf("stg c%0d wren", c), app_wdf_wren, (c <= 3));
            chk($sformatf("stg c%0d wdf_end", c), app_wdf_end, (c <= 3));
            if (c == 0) begin
                chk("stg wdf_mask", app_wdf_mask, 16'h00FF);
                chk("stg wdf_data", app_wdf_data, {4{32'hA5A50F0F}});
                chk("stg app_addr", app_addr, 28'h0000020);
            end
        end
        chk("stg cmd handshakes", n_cmd_hs - cmd0, 1);
        chk("stg wdf handshakes", n_wdf_hs - wdf0, 1);
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;

        // Arbitration / eligibility table (last grant is p1 here)
        for (int i = 0; i < 7; i++) begin
            @(negedge ui_clk);
            init_calib_complete = vecs[i].calib;
            p0_req_valid = vecs[i].v0; p0_req_write = vecs[i].w0; p0_req_addr = 28'h100 + 28'(i);
            p1_req_valid = vecs[i].v1; p1_req_write = vecs[i].w1; p1_req_addr = 28'h200 + 28'(i);
            #1;
            chk($sformatf("vec%0d ready0", i), p0_req_ready, vecs[i].g0);
            chk($sformatf("vec%0d ready1", i), p1_req_ready, vecs[i].g1);
            exp_en   = vecs[i].g0 | vecs[i].g1;
            exp_wr   = vecs[i].g1 ? vecs[i].w1 : vecs[i].w0;
            exp_cmd  = exp_wr ? 3'b000 : 3'b001;
            exp_addr = vecs[i].g1 ? 28'h200 + 28'(i) : 28'h100 + 28'(i);
            @(negedge ui_clk);
            #1;
            chk($sformatf("vec%0d app_en", i), app_en, exp_en);
            chk($sformatf("vec%0d wren", i), app_wdf_wren, exp_en & exp_wr);
            chk($sformatf("vec%0d issue ready0", i), p0_req_ready, 0);
            chk($sformatf("vec%0d issue ready1", i), p1_req_ready, 0);
            if (exp_en) begin
                chk($sformatf("vec%0d app_cmd", i), app_cmd, exp_cmd);
                chk($sformatf("vec%0d app_addr", i), app_addr, exp_addr);
            end
        end

        // FIFO full (tags 0,1,0,1): read held off until one return
        @(negedge ui_clk);
        init_calib_complete = 1'b1;
        p1_req_valid = 1'b0;
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000300;
        #1;
        chk("full p0 blocked", p0_req_ready, 0);
        do_return({4{32'hD000000A}}, 1'b0);
        chk("full p0 granted after pop", p0_req_ready, 1);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        #1;
        chk("full rd app_en", app_en, 1);
        chk("full rd app_cmd", app_cmd, 3'b001);
        chk("full rd app_addr", app_addr, 28'h0000300);
        do_return({4{32'hD000000B}}, 1'b1);
        do_return({4{32'hD000000C}}, 1'b0);
        do_return({4{32'hD000000D}}, 1'b1);
        do_return({4{32'hD000000E}}, 1'b0);

        // Read return ordering p0,p1,p1,p0
        issue_read(1'b0, 28'h0000400);
        issue_read(1'b1, 28'h0000404);
        issue_read(1'b1, 28'h0000408);
        issue_read(1'b0, 28'h000040C);
        do_return({4{32'hD0D0D0D0}}, 1'b0);
        do_return({4{32'hD1D1D1D1}}, 1'b1);
        do_return({4{32'hD2D2D2D2}}, 1'b1);
        do_return({4{32'hD3D3D3D3}}, 1'b0);

        // Push and pop in the same cycle
        issue_read(1'b1, 28'h0000500);
        @(negedge ui_clk);
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000504;
        #1;
        chk("pp ready0", p0_req_ready, 1);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        app_rd_data = {4{32'hE0E0E0E0}};
        app_rd_data_valid = 1'b1;
        #1;
        chk("pp app_en", app_en, 1);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        chk("pp rsp1_valid", p1_rsp_valid, 1);
        chk("pp rsp1_data", p1_rsp_data, {4{32'hE0E0E0E0}});
        chk("pp rsp0_valid", p0_rsp_valid, 0);
        do_return({4{32'hE1E1E1E1}}, 1'b0);

        // Unexpected read data
        @(negedge ui_clk);
        app_rd_data = {4{32'hBADBAD00}};
        app_rd_data_valid = 1'b1;
        #1;
        chk("err before", err_unexpected_rd, 0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        chk("err set", err_unexpected_rd, 1);
        chk("err rsp0_valid", p0_rsp_valid, 0);
        chk("err rsp1_valid", p1_rsp_valid, 0);
        @(negedge ui_clk);
        #1;
        chk("err sticky", err_unexpected_rd, 1);

        // Reset in the middle of ISSUE, then last_grant must be back at 1
        @(negedge ui_clk);
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        p0_req_valid = 1'b1; p0_req_write = 1'b1; p0_req_addr = 28'h0000600;
        p0_req_wdata = {4{32'h66666666}}; p0_req_wmask = 16'h0F0F;
        #1;
        chk("rst grant ready0", p0_req_ready, 1);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        #1;
        chk("rst pre app_en", app_en, 1);
        chk("rst pre wren", app_wdf_wren, 1);
        ui_clk_sync_rst = 1'b1;
        p1_req_valid = 1'b1; p1_req_write = 1'b0; p1_req_addr = 28'h0000704;
        @(negedge ui_clk);
        #1;
        check_all_zero("midrst");
        ui_clk_sync_rst = 1'b0;
        app_rdy = 1'b1;
        p0_req_valid = 1'b1; p0_req_write = 1'b0; p0_req_addr = 28'h0000700;
        #1;
        chk("post rst ready0", p0_req_ready, 1);
        chk("post rst ready1", p1_req_ready, 0);
        @(negedge ui_clk);
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        #1;
        chk("post rst app_en", app_en, 1);
        chk("post rst app_addr", app_addr, 28'h0000700);

        repeat (3) @(negedge ui_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_app_arbiter.md
# ddr_app_arbiter

Two-port arbiter that shares the single MIG 7-series user (app_*) interface between two independent requesters, such as a test/pattern engine and a host bridge. It sits between the requesters and the memory controller in the ui_clk domain. It issues single-beat (one 128-bit app word, BL8 on the x16 DDR3) reads and writes, keeps write data aligned with its command, and returns read data to the originating port in issue order.

## Interface
- ADDR_WIDTH, 28, app address width
- APP_DATA_WIDTH, 128, app data width
- MASK_WIDTH, 16, byte mask width (APP_DATA_WIDTH/8)
- RD_FIFO_DEPTH, 16, max outstanding reads (power of 2)

Ports. pN denotes the identical set for N in {0,1}.
- ui_clk  in  1  sole clock
- ui_clk_sync_rst  in  1  reset; synchronous, active-high
- init_calib_complete  in  1  no grants while low
- pN_req_valid  in  1  request pending
- pN_req_ready  out  1  request accepted this cycle
- pN_req_write  in  1  1=write, 0=read
- pN_req_addr  in  ADDR_WIDTH  app address
- pN_req_wdata  in  APP_DATA_WIDTH  write data
- pN_req_wmask  in  MASK_WIDTH  1=byte not written
- pN_rsp_valid  out  1  read data valid, one-cycle pulse, no backpressure
- pN_rsp_data  out  APP_DATA_WIDTH  read data
- app_addr/app_cmd/app_en  out  ADDR_WIDTH/3/1  MIG command; app_cmd 3'b000=write, 3'b001=read
- app_rdy  in  1  command accepted
- app_wdf_data/app_wdf_mask/app_wdf_wren/app_wdf_end  out  APP_DATA_WIDTH/MASK_WIDTH/1/1  write data
- app_wdf_rdy  in  1  write data accepted
- app_rd_data/app_rd_data_valid/app_rd_data_end  in  APP_DATA_WIDTH/1/1  read return
- err_unexpected_rd  out  1  sticky: read data arrived with tag FIFO empty

## Operation
- States: IDLE and ISSUE.
- IDLE: when init_calib_complete=1 and an eligible request exists, grant one port. The grant asserts pN_req_ready combinationally in the same cycle and latches write, addr, wdata and wmask into holding registers. Next state is ISSUE.
- Eligibility: a read is eligible only when the tag FIFO count < RD_FIFO_DEPTH. A write is always eligible.
- Arbitration: round-robin on a last_grant register, reset to 1 so port 0 wins first. When both ports are eligible, grant the port that is not last_grant. With only one eligible port, grant it. last_grant updates on every grant.
- ISSUE: app_en=1 with held addr and cmd until app_en&&app_rdy, which sets cmd_done.
  - For writes, app_wdf_wren=app_wdf_end=1 with held data and mask until app_wdf_wren&&app_wdf_rdy, which sets wdf_done.
  - Command and data handshakes complete independently in any order or the same cycle. Each is deasserted the cycle after its own completion.
  - Return to IDLE in the cycle after both required handshakes are done. Reads need only cmd_done.
- Tag FIFO: the granted port id is pushed when a read's command handshake completes. On app_rd_data_valid, pop the head, drive app_rd_data onto that port's rsp_data, and pulse its rsp_valid. The other port's rsp_valid stays 0.
- Simultaneous push and pop: the count is unchanged. Read pointers wrap modulo RD_FIFO_DEPTH.
- app_rd_data_valid with the FIFO empty: data is dropped and err_unexpected_rd is set until reset.
- init_calib_complete falling mid-ISSUE: the current transaction completes; no new grants are made.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, last_grant=1, err_unexpected_rd=0.
- Reset asserted mid-ISSUE aborts the transaction with no completion; the MIG is reset by the same signal.
- Request to app_en: 1 cycle (grant cycle, then ISSUE).
- Maximum rate: one command per 2 cycles when app_rdy and app_wdf_rdy are high.
- Read data to pN_rsp_valid: 1 cycle, registered.
- Requesters hold valid and payload stable until ready. ready is never asserted outside IDLE.

## Configuration
- DDR_ARB_FIXED_PRIORITY_EN defined: port 0 always wins when both are eligible, and last_grant is unused.
- Not defined: round-robin as described above.

## Test plan
- Single write: p0 writes addr 0x0000010, data 0x0123…CDEF, mask 0 → app_en with app_cmd=000 and app_wdf_wren in the same cycle, 1 cycle after grant. p0_req_ready pulses once.
- Write with staggered ready: app_wdf_rdy low 3 cycles, app_rdy low 5 cycles → wren drops the cycle after its own handshake, app_en drops after its own, FSM returns to IDLE once both are done. No duplicate handshake.
- Contention: both ports request reads continuously → grants alternate p0,p1,p0,p1. With DDR_ARB_FIXED_PRIORITY_EN defined, all grants go to p0.
- Read return: 4 reads p0,p1,p1,p0; MIG returns D0..D3 → p0 gets D0 and D3, p1 gets D1 and D2, each 1 cycle after its app_rd_data_valid.
- FIFO full: RD_FIFO_DEPTH=4, 4 reads outstanding, no returns → 5th read is not granted while a p1 write is granted. After one return, the 5th read is granted.
- Error/reset: app_rd_data_valid with no outstanding reads → err_unexpected_rd=1 and no rsp_valid. Reset mid-ISSUE → all outputs 0 on the next cycle and err cleared.
